cpu_if_addr_decoder: RTL and testbench

Fast-clock-side consumer of the CPU access bus produced by the CPU interface clock-domain crossing. Takes single-cycle read/write strobes, decodes the word address into one of `NUM_SLAVES` register regions and forwards the access as a single-cycle strobe. It waits for the selected slave's `access_complete` and returns read data plus a completion pulse upstream. A per-access timeout and an out-of-map decode check guarantee that every upstream request completes, so the crossing's control FSM can never hang.

---
 rtl/cpu_if_addr_decoder_pkg.sv | 19 +
 rtl/cpu_if_addr_decoder_if.sv | 23 ++
 rtl/cpu_if_addr_decoder_timeout_counter.sv | 30 +++
 rtl/cpu_if_addr_decoder.sv | 160 ++++++++++++++++
 tb/tb_cpu_if_addr_decoder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_if_addr_decoder_pkg.sv
// Shared definitions for the fast-domain CPU bus agents.
// Holds the decoder FSM states, the error read-data pattern and the select-field width.
package cpu_if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } cpu_if_dec_state_e;

    localparam int unsigned CPU_IF_SEL_W    = 4;
    localparam logic [31:0] CPU_IF_ERR_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } cpu_if_resp_t;

endpackage

// File: rtl/cpu_if_addr_decoder_if.sv
// Upstream CPU access bus between the clock-domain crossing and the address decoder.
// The crossing drives requests through `master`; the decoder answers through `slave`.
interface cpu_if_addr_decoder_if;

    logic        read;
    logic        write;
    logic [31:2] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        access_complete;
    logic        bus_error;

    modport master (
        output read, write, address, write_data,
        input  read_data, access_complete, bus_error
    );

    modport slave (
        input  read, write, address, write_data,
        output read_data, access_complete, bus_error
    );

endinterface

// File: rtl/cpu_if_addr_decoder_timeout_counter.sv
// Saturating wait-state counter shared by the CPU-bus agents.
// `expired` rises in the enabled cycle that brings the count to TIMEOUT_CYCLES and stays high while saturated.
module cpu_if_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned    CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Look-ahead on the final step lets the owner act on the same edge the limit is reached.
    assign expired = (count_q == LIMIT) || (enable && (count_q == LIMIT - 1'b1));

endmodule

// File: rtl/cpu_if_addr_decoder.sv
// Fast-domain address decoder: forwards single-cycle CPU strobes to one of NUM_SLAVES regions
// and guarantees a completion for every request via decode-error and timeout responses.
module cpu_if_addr_decoder
    import cpu_if_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned SEL_LSB        = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    cpu_if_addr_decoder_if.slave        bus,
    output logic [NUM_SLAVES-1:0]       s_read,
    output logic [NUM_SLAVES-1:0]       s_write,
    output logic [31:2]                 s_address,
    output logic [31:0]                 s_write_data,
    input  logic [NUM_SLAVES-1:0][31:0] s_read_data,
    input  logic [NUM_SLAVES-1:0]       s_access_complete
);

    localparam logic [CPU_IF_SEL_W:0] NUM_SLAVES_L = (CPU_IF_SEL_W + 1)'(NUM_SLAVES);

    cpu_if_dec_state_e state_q, state_d;

    logic                    req;
    logic [CPU_IF_SEL_W-1:0] req_sel;
    logic                    req_in_map;
    logic [NUM_SLAVES-1:0]   req_oh;
    logic [NUM_SLAVES-1:0]   sel_oh_q;
    logic                    slave_done;
    logic [31:0]             sel_rdata;
    logic                    expired;
    logic                    cnt_enable;
    logic                    cnt_clear;
    logic                    resp_load;
    cpu_if_resp_t            resp_d;

    logic [31:0]             read_data_q;
    logic                    access_complete_q;
    logic                    bus_error_q;

    assign req        = bus.read | bus.write;
    assign req_sel    = bus.address[SEL_LSB + CPU_IF_SEL_W - 1 : SEL_LSB];
    assign req_in_map = ({1'b0, req_sel} < NUM_SLAVES_L);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        req_oh = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            req_oh[i] = (req_sel == CPU_IF_SEL_W'(i));
        end
    end

    // Only the selected slave's completion and data matter; the rest are masked off.
    assign slave_done = |(s_access_complete & sel_oh_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_oh_q[i]) begin
                sel_rdata = sel_rdata | s_read_data[i];
            end
        end
    end

    assign cnt_enable = (state_q == WAIT) && !slave_done;
    assign cnt_clear  = (state_q != WAIT);

    cpu_if_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        resp_load   = 1'b0;
        resp_d.err  = 1'b0;
        resp_d.data = sel_rdata;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (req_in_map) begin
                        state_d = WAIT;
                    end else begin
                        state_d     = RESP;
                        resp_load   = 1'b1;
                        resp_d.err  = 1'b1;
                        resp_d.data = CPU_IF_ERR_DATA;
                    end
                end
            end
            WAIT: begin
                // Completion is checked first so it wins over a same-cycle expiry.
                if (slave_done) begin
                    state_d   = RESP;
                    resp_load = 1'b1;
                end else if (expired) begin
                    state_d     = RESP;
                    resp_load   = 1'b1;
                    resp_d.err  = 1'b1;
                    resp_d.data = CPU_IF_ERR_DATA;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the registered datapath is reset too, because the shared bus must read as zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            sel_oh_q          <= '0;
            s_read            <= '0;
            s_write           <= '0;
            s_address         <= '0;
            s_write_data      <= '0;
            read_data_q       <= '0;
            access_complete_q <= 1'b0;
            bus_error_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            s_read            <= '0;
            s_write           <= '0;
            access_complete_q <= resp_load;
            bus_error_q       <= resp_load & resp_d.err;

            if ((state_q == IDLE) && req) begin
                s_address    <= bus.address;
                s_write_data <= bus.write_data;
                sel_oh_q     <= req_oh;
                if (req_in_map) begin
                    if (bus.write) begin
                        s_write <= req_oh;
                    end else begin
                        s_read  <= req_oh;
                    end
                end
            end

            if (resp_load) begin
                read_data_q <= resp_d.data;
            end
        end
    end

    assign bus.read_data       = read_data_q;
    assign bus.access_complete = access_complete_q;
    assign bus.bus_error       = bus_error_q;

endmodule

// File: tb/tb_cpu_if_addr_decoder.sv
// Directed bench for cpu_if_addr_decoder: vector table for single accesses plus hand sequences
// for busy/wrong-slave requests, back-to-back acceptance and reset mid-access.
module tb_cpu_if_addr_decoder;

    import cpu_if_pkg::*;

    localparam int NS = 4;
    localparam int SL = 12;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cpu_if_addr_decoder_if bus ();

    logic [NS-1:0]       s_read;
    logic [NS-1:0]       s_write;
    logic [31:2]         s_address;
    logic [31:0]         s_write_data;
    logic [NS-1:0][31:0] s_read_data;
    logic [NS-1:0]       s_access_complete;

    cpu_if_addr_decoder #(
        .NUM_SLAVES     (NS),
        .SEL_LSB        (SL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .s_read            (s_read),
        .s_write           (s_write),
        .s_address         (s_address),
        .s_write_data      (s_write_data),
        .s_read_data       (s_read_data),
        .s_access_complete (s_access_complete)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // delay = cycles after the strobe cycle in which the slave pulses complete; -1 = never.
    // exp_lat = cycle of access_complete counted from the request-sampling edge T.
    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] byte_addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] sdata;
        logic [3:0]  exp_rd;
        logic [3:0]  exp_wr;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic idle_inputs();
        bus.read          = 1'b0;
        bus.write         = 1'b0;
        bus.address       = '0;
        bus.write_data    = '0;
        s_access_complete = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int          sel;
        int          lat;
        int          ac_count;
        logic        stray;
        logic        err;
        logic [31:0] rdata;
        sel = int'(v.byte_addr[SL+3:SL]);
        for (int i = 0; i < NS; i++) s_read_data[i] = 32'h0BAD_0000 | 32'(i);
        if (sel < NS) s_read_data[sel] = v.sdata;
        @(negedge clk);
        bus.read       = v.rd;
        bus.write      = v.wr;
        bus.address    = v.byte_addr[31:2];
        bus.write_data = v.wdata;
        @(negedge clk);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        lat = 0; ac_count = 0; stray = 1'b0; err = 1'b0; rdata = '0;
        for (int n = 1; n <= TO + 4; n++) begin
            if (n == 1) begin
                check($sformatf("%s s_read", v.name), 32'(s_read), 32'(v.exp_rd));
                check($sformatf("%s s_write", v.name), 32'(s_write), 32'(v.exp_wr));
                if ((v.exp_rd | v.exp_wr) != 4'd0)
                    check($sformatf("%s s_address", v.name), 32'(s_address), 32'(v.byte_addr[31:2]));
                if (v.exp_wr != 4'd0)
                    check($sformatf("%s s_write_data", v.name), s_write_data, v.wdata);
            end else if ((s_read | s_write) != '0) begin
                stray = 1'b1;
            end
            if (bus.access_complete) begin
                ac_count++;
                if (lat == 0) begin
                    lat   = n;
                    err   = bus.bus_error;
                    rdata = bus.read_data;
                end
            end
            s_access_complete = '0;
            if (v.delay >= 0 && n == 1 + v.delay && sel < NS) s_access_complete[sel] = 1'b1;
            @(negedge clk);
        end
        s_access_complete = '0;
        check($sformatf("%s stray_strobe", v.name), 32'(stray), 32'd0);
        check($sformatf("%s latency", v.name), 32'(lat), 32'(v.exp_lat));
        check($sformatf("%s complete_count", v.name), 32'(ac_count), 32'd1);
        check($sformatf("%s bus_error", v.name), 32'(err), 32'(v.exp_err));
        check($sformatf("%s read_data", v.name), rdata, v.exp_rdata);
        check($sformatf("%s read_data_hold", v.name), bus.read_data, v.exp_rdata);
    endtask

    initial begin
        logic [15:0] ac_mask;
        logic        wr_seen;

        //         name        rd    wr    byte_addr     wdata         dly sdata         exp_rd  exp_wr  lat err   exp_rdata
        vecs[0] = '{"rd_3ws",   1'b1, 1'b0, 32'h0000_1004, 32'h0,        3, 32'h1234_5678, 4'b0010, 4'b0000, 5, 1'b0, 32'h1234_5678};
        vecs[1] = '{"wr_0ws",   1'b0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 0, 32'h0000_1111, 4'b0000, 4'b0001, 2, 1'b0, 32'h0000_1111};
        vecs[2] = '{"dec_err5", 1'b1, 1'b0, 32'h0000_5000, 32'h0,       -1, 32'h0,         4'b0000, 4'b0000, 1, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{"timeout",  1'b1, 1'b0, 32'h0000_2000, 32'h0,       -1, 32'h2222_0000, 4'b0100, 4'b0000, 9, 1'b1, 32'hDEAD_BEEF};
        vecs[4] = '{"late_ok",  1'b1, 1'b0, 32'h0000_3000, 32'h0,        7, 32'h3333_4444, 4'b1000, 4'b0000, 9, 1'b0, 32'h3333_4444};
        vecs[5] = '{"rd_and_wr",1'b1, 1'b1, 32'hFFFF_3008, 32'h0F0F_0F0F, 1, 32'h5555_AAAA, 4'b0000, 4'b1000, 3, 1'b0, 32'h5555_AAAA};
        vecs[6] = '{"dec_err15",1'b0, 1'b1, 32'h0000_F000, 32'h0000_0001,-1, 32'h0,         4'b0000, 4'b0000, 1, 1'b1, 32'hDEAD_BEEF};
        vecs[7] = '{"to_minus1",1'b1, 1'b0, 32'h0000_0FFC, 32'h0,        6, 32'h7777_6666, 4'b0001, 4'b0000, 8, 1'b0, 32'h7777_6666};

        idle_inputs();
        s_read_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst s_read", 32'(s_read), 32'd0);
        check("rst s_write", 32'(s_write), 32'd0);
        check("rst access_complete", 32'(bus.access_complete), 32'd0);
        check("rst bus_error", 32'(bus.bus_error), 32'd0);
        check("rst read_data", bus.read_data, 32'd0);
        check("rst s_address", 32'(s_address), 32'd0);
        check("rst s_write_data", s_write_data, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Wrong-slave completion and busy requests are ignored; a request in RESP is dropped,
        // one in the following IDLE cycle is accepted.
        s_read_data[0] = 32'h0000_AAAA;
        s_read_data[1] = 32'h1111_2222;
        s_read_data[2] = 32'h2222_3333;
        s_read_data[3] = 32'h3333_0000;
        @(negedge clk);
        bus.read    = 1'b1;
        bus.address = 30'h0000_0400;
        @(negedge clk);
        idle_inputs();
        ac_mask = '0;
        wr_seen = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (bus.access_complete) ac_mask[n] = 1'b1;
            if (s_write != '0) wr_seen = 1'b1;
            if (n == 1) check("busy s_read_first", 32'(s_read), 32'b0010);
            if (n == 5) begin
                check("busy bus_error", 32'(bus.bus_error), 32'd0);
                check("busy read_data", bus.read_data, 32'h1111_2222);
            end
            if (n == 6) check("b2b resp_req_dropped", 32'(s_read), 32'd0);
            if (n == 7) check("b2b s_read", 32'(s_read), 32'b0001);
            if (n == 8) check("b2b read_data", bus.read_data, 32'h0000_AAAA);
            idle_inputs();
            case (n)
                2: begin
                    s_access_complete = 4'b0100;
                    bus.write         = 1'b1;
                    bus.address       = '0;
                    bus.write_data    = 32'h0000_0099;
                end
                4: s_access_complete = 4'b0010;
                5, 6: begin
                    bus.read    = 1'b1;
                    bus.address = '0;
                end
                7: s_access_complete = 4'b0001;
                default: ;
            endcase
            @(negedge clk);
        end
        idle_inputs();
        check("busy complete_cycles", 32'(ac_mask), 32'h0000_0120);
        check("busy no_write_strobe", 32'(wr_seen), 32'd0);

        // Reset during WAIT abandons the access; a late completion in IDLE is ignored.
        @(negedge clk);
        bus.read       = 1'b1;
        bus.address    = 30'h0000_0400;
        bus.write_data = 32'h0000_0055;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst s_read", 32'(s_read), 32'd0);
        check("mid_rst s_write", 32'(s_write), 32'd0);
        check("mid_rst access_complete", 32'(bus.access_complete), 32'd0);
        check("mid_rst bus_error", 32'(bus.bus_error), 32'd0);
        check("mid_rst read_data", bus.read_data, 32'd0);
        check("mid_rst s_address", 32'(s_address), 32'd0);
        check("mid_rst s_write_data", s_write_data, 32'd0);
        reset             = 1'b0;
        s_access_complete = 4'b0010;
        @(negedge clk);
        s_access_complete = '0;
        ac_mask = '0;
        for (int n = 0; n < 6; n++) begin
            if (bus.access_complete) ac_mask[n] = 1'b1;
            @(negedge clk);
        end
        check("mid_rst no_complete", 32'(ac_mask), 32'd0);
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
